tmr32_pin_cond: RTL and testbench
=================================

Name: tmr32_pin_cond

Overview:
- Input conditioner that sits directly upstream of the 32-bit timer's external-pin input (EXTPIN).
- Synchronises an asynchronous pad signal and rejects glitches with a programmable stability filter.
- Produces a clean level for the timer's EXTPIN, plus one-cycle edge-event pulses selected the same way as the timer's PNE/BE controls.
- Keeps a saturating count of rejected glitches for software diagnostics.

Parameters:
- FLT_W, 4: width of the filter-length control and the stability counter.
- GC_W, 8: width of the saturating glitch counter.

Ports:
- clk  in  1  Single clock. All state is clocked on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- en  in  1  Enables event outputs and glitch counting.
- pin_in  in  1  Asynchronous pad input.
- flt_len  in  FLT_W  Filter length N. An input change is accepted after N+1 stable cycles; N=0 gives minimum latency.
- pne  in  1  Edge select: 0 = positive edge, 1 = negative edge.
- be  in  1  Both edges. When 1, overrides pne.
- glitch_clr  in  1  Synchronous clear of glitch_cnt.
- pin_out  out  1  Filtered level. Drives the timer's EXTPIN.
- pos_evt  out  1  One-cycle pulse on a rising edge of pin_out.
- neg_evt  out  1  One-cycle pulse on a falling edge of pin_out.
- evt  out  1  Selected edge event, gated by en.
- glitch_cnt  out  GC_W  Number of rejected input excursions, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge of clk):
  - s1, s2, pin_out, pin_q, cnt and glitch_cnt all become 0.
  - All outputs are 0 on the cycle after reset.
- Synchroniser: two flops, pin_in -> s1 -> s2. No logic between the stages.
- Filter, evaluated every cycle regardless of en:
  - If s2 == pin_out: cnt <= 0. If additionally cnt != 0 and en=1, this is a glitch and glitch_cnt increments.
  - Else if cnt >= flt_len: pin_out <= s2 and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - The compare is >=, so lowering flt_len mid-count accepts the change on the next cycle. cnt never wraps.
- Latency: a pin_in change sampled at edge k appears on pin_out after edge k+N+2, where N = flt_len.
  - N=0 gives 2 cycles.
  - N=15 gives 17 cycles.
- Edge detection:
  - pin_q <= pin_out every cycle.
  - pos_evt = pin_out & ~pin_q and neg_evt = ~pin_out & pin_q, decoded combinationally from registers.
  - Each pulse lasts exactly one cycle. pos_evt and neg_evt are never high together.
- Event select:
  - evt = en & (be ? (pos_evt | neg_evt) : (pne ? neg_evt : pos_evt)).
  - pos_evt and neg_evt are not gated by en.
- en=0:
  - Synchroniser and filter keep running, so pin_out stays valid.
  - evt is forced to 0.
  - glitch_cnt is frozen.
- Glitch counter:
  - Saturates at 2^GC_W-1 with no wrap.
  - glitch_clr=1 sets it to 0. Clear has priority over a simultaneous increment, so that increment is lost.
- After reset, if pin_in is held high, pin_out rises after the normal latency and a pos_evt is produced. This is intentional and is not suppressed.
- rst asserted mid-filter: cnt is discarded and pin_out returns to 0 on the next cycle. No event is generated by the reset itself.
- Changes to pne and be take effect combinationally in the same cycle.

Decomposition:
- Shared timer package holds:
  - edge-select encodings: EDGE_POS=0, EDGE_NEG=1;
  - default widths FLT_W=4 and GC_W=8.
- One sub-module, tmr32_sync2: a two-flop synchroniser with synchronous active-high reset. It is reusable for other pad inputs.
- The filter, edge detection and glitch counter stay in the top module.

Test Plan:
- Latency, N=0: rst released, en=1, flt_len=0, pne=0, pin_in rises just before edge k -> pin_out=1 after edge k+2, evt and pos_evt high for exactly one cycle, glitch_cnt=0.
- Latency, N=3: flt_len=3, pin_in high for 10 cycles -> pin_out rises after edge k+5; then pin_in falls -> pin_out falls 5 cycles later, neg_evt pulses, evt stays 0.
- Glitch rejection: flt_len=3, pin_in high 2 cycles then low -> pin_out stays 0, glitch_cnt=1. Repeat 300 times -> glitch_cnt=255 (saturated). glitch_clr asserted in the same cycle as a glitch -> glitch_cnt=0.
- Edge select: toggle pin_in every 20 cycles.
  - be=1 -> evt on both edges.
  - pne=1, be=0 -> evt only on falling edges.
  - en=0 -> evt=0 throughout, while pos_evt and neg_evt still pulse.
- Mid-count change and reset: flt_len=15, pin_in high, at cnt=8 set flt_len=4 -> pin_out rises on the next edge. Separately, assert rst at cnt=6 -> pin_out=0, cnt restarts, no evt.
- Timer integration: drive the timer's EXTPIN from pin_out with the timer in counter mode, PRE=3, and a 157-time-unit toggle on pin_in, clk period 10 -> the timer count advances once per selected filtered edge, with no extra counts from injected 1-cycle spikes when flt_len=2.

Source files
------------

// File: rtl/tmr32_pin_cond_pkg.sv
// -----------------------------------------------------------------------------
// tmr32_pin_cond_pkg
// Shared definitions for the 32-bit timer's external-pin conditioning path.
//   - edge_sel_e : encoding of the PNE edge-select control
//   - DEF_FLT_W  : default width of the filter length / stability counter
//   - DEF_GC_W   : default width of the saturating glitch counter
//   - edge_pick  : applies the PNE/BE selection to a pair of edge pulses
// -----------------------------------------------------------------------------
package tmr32_pin_cond_pkg;

   localparam int DEF_FLT_W = 4;
   localparam int DEF_GC_W  = 8;

   typedef enum logic {
      EDGE_POS = 1'b0,
      EDGE_NEG = 1'b1
   } edge_sel_e;

   // BE overrides PNE; with BE low, PNE picks exactly one edge polarity.
   function automatic logic edge_pick(input logic      i_be,
                                      input edge_sel_e i_sel,
                                      input logic      i_pos,
                                      input logic      i_neg);
      logic w_sel;
      if (i_be)
         w_sel = i_pos | i_neg;
      else if (i_sel == EDGE_NEG)
         w_sel = i_neg;
      else
         w_sel = i_pos;
      return w_sel;
   endfunction

endpackage

// File: rtl/tmr32_sync2.sv
// -----------------------------------------------------------------------------
// tmr32_sync2
// Two-flop synchroniser for an asynchronous pad input. Nothing sits between
// the two stages so the first flop has a full cycle to resolve.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset, clears both stages
//   i_d   : asynchronous input
//   o_q   : synchronised output (second stage)
// -----------------------------------------------------------------------------
module tmr32_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/tmr32_pin_cond.sv
// -----------------------------------------------------------------------------
// tmr32_pin_cond
// Conditions the asynchronous external pin that feeds the 32-bit timer's
// EXTPIN: synchronise, filter out short excursions, produce edge pulses and
// count how many excursions were rejected.
// Ports:
//   i_clk        : clock, all state on the rising edge
//   i_rst        : synchronous active-high reset
//   i_en         : enables o_evt and glitch counting
//   i_pin_in     : asynchronous pad input
//   i_flt_len    : filter length N; a change is accepted after N+1 stable cycles
//   i_pne        : edge select, 0 = rising, 1 = falling
//   i_be         : both edges, overrides i_pne
//   i_glitch_clr : synchronous clear of o_glitch_cnt (wins over an increment)
//   o_pin_out    : filtered level for EXTPIN
//   o_pos_evt    : one-cycle pulse on a rising edge of o_pin_out
//   o_neg_evt    : one-cycle pulse on a falling edge of o_pin_out
//   o_evt        : selected edge pulse, gated by i_en
//   o_glitch_cnt : saturating count of rejected excursions
// -----------------------------------------------------------------------------
module tmr32_pin_cond
   import tmr32_pin_cond_pkg::*;
#(
   parameter int FLT_W = DEF_FLT_W,
   parameter int GC_W  = DEF_GC_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_pin_in,
   input  logic [FLT_W-1:0] i_flt_len,
   input  logic             i_pne,
   input  logic             i_be,
   input  logic             i_glitch_clr,
   output logic             o_pin_out,
   output logic             o_pos_evt,
   output logic             o_neg_evt,
   output logic             o_evt,
   output logic [GC_W-1:0]  o_glitch_cnt
);

   logic             w_s2;
   logic             r_pin_out;
   logic             r_pin_q;
   logic [FLT_W-1:0] r_cnt;
   logic [GC_W-1:0]  r_glitch_cnt;

   logic             w_same;
   logic             w_accept;
   logic             w_glitch;
   logic             w_gc_sat;
   logic             w_pos;
   logic             w_neg;

   tmr32_sync2 u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_pin_in),
      .o_q   (w_s2)
   );

   // The input has returned to the accepted level. A non-zero count means
   // it had been away for at least one cycle without being accepted.
   assign w_same   = (w_s2 == r_pin_out);
   assign w_glitch = w_same && (r_cnt != '0) && i_en;

   // >= rather than == so that lowering i_flt_len below a running count
   // accepts on the next cycle instead of letting the counter run past it.
   assign w_accept = !w_same && (r_cnt >= i_flt_len);

   // Stability filter; runs regardless of i_en so o_pin_out is always valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pin_out <= 1'b0;
         r_cnt     <= '0;
      end else if (w_same) begin
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_pin_out <= w_s2;
         r_cnt     <= '0;
      end else begin
         r_cnt     <= r_cnt + FLT_W'(1);
      end
   end

   // Previous filtered level for edge decoding.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_pin_q <= 1'b0;
      else
         r_pin_q <= r_pin_out;
   end

   // Saturating glitch counter. Clear is honoured even with i_en low; only
   // the increment is gated, which is what freezes the count.
   assign w_gc_sat = &r_glitch_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_glitch_cnt <= '0;
      else if (i_glitch_clr)
         r_glitch_cnt <= '0;
      else if (w_glitch && !w_gc_sat)
         r_glitch_cnt <= r_glitch_cnt + GC_W'(1);
   end

   // Both pulses decode from registers only, so they are glitch-free and
   // can never be high together.
   assign w_pos = r_pin_out & ~r_pin_q;
   assign w_neg = ~r_pin_out & r_pin_q;

   assign o_pin_out    = r_pin_out;
   assign o_pos_evt    = w_pos;
   assign o_neg_evt    = w_neg;
   assign o_evt        = i_en & edge_pick(i_be, edge_sel_e'(i_pne), w_pos, w_neg);
   assign o_glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_tmr32_pin_cond.sv
`timescale 1ns/1ps
module tb_tmr32_pin_cond;

   logic       clk = 1'b0;
   logic       rst, en, pin, pne, be, clr;
   logic [3:0] flt;
   logic       o_pin_out, o_pos_evt, o_neg_evt, o_evt;
   logic [7:0] o_glitch_cnt;

   int vec  = 0;
   int miss = 0;
   int evt_cnt, pos_cnt, neg_cnt;

   // Reference model: the pad samples seen by the filter, kept as history.
   bit q[$];      // values taken by the first sync stage (last two = s1, s2)
   bit d[$];      // stream of synchronised samples the filter has judged
   bit mo, mq;    // accepted level and its previous-cycle value
   int gc;

   always #5 clk = ~clk;

   tmr32_pin_cond dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_pin_in     (pin),
      .i_flt_len    (flt),
      .i_pne        (pne),
      .i_be         (be),
      .i_glitch_clr (clr),
      .o_pin_out    (o_pin_out),
      .o_pos_evt    (o_pos_evt),
      .o_neg_evt    (o_neg_evt),
      .o_evt        (o_evt),
      .o_glitch_cnt (o_glitch_cnt)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vec++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // A level is accepted once the most recent run of differing samples is
   // longer than the filter length; a run that ends early is a glitch.
   task automatic model_edge();
      bit s2b, glitch;
      int run;
      if (rst) begin
         q.delete(); q.push_back(1'b0); q.push_back(1'b0);
         d.delete();
         mo = 0; mq = 0; gc = 0;
      end else begin
         s2b = q[q.size()-2];
         q.push_back(pin);
         if (q.size() > 4) void'(q.pop_front());
         d.push_back(s2b);
         if (d.size() > 40) void'(d.pop_front());
         glitch = 0;
         mq = mo;
         if (s2b == mo) begin
            glitch = en && d.size() >= 2 && d[d.size()-2] != mo;
         end else begin
            run = 0;
            for (int i = d.size()-1; i >= 0 && d[i] != mo; i--) run++;
            if (run >= int'(flt) + 1) mo = s2b;
         end
         if (clr) gc = 0;
         else if (glitch && gc < 255) gc++;
      end
   endtask

   task automatic step();
      bit ep, en_, ev;
      @(posedge clk);
      model_edge();
      #1;
      ep  = mo & ~mq;
      en_ = ~mo & mq;
      ev  = en & (be ? (ep | en_) : (pne ? en_ : ep));
      chk("pin_out",    {7'd0, o_pin_out}, {7'd0, mo});
      chk("pos_evt",    {7'd0, o_pos_evt}, {7'd0, ep});
      chk("neg_evt",    {7'd0, o_neg_evt}, {7'd0, en_});
      chk("evt",        {7'd0, o_evt},     {7'd0, ev});
      chk("glitch_cnt", o_glitch_cnt,      gc[7:0]);
      if (o_evt === 1'b1)     evt_cnt++;
      if (o_pos_evt === 1'b1) pos_cnt++;
      if (o_neg_evt === 1'b1) neg_cnt++;
   endtask

   task automatic toggle_phase();
      evt_cnt = 0; pos_cnt = 0; neg_cnt = 0;
      repeat (4) begin
         pin = ~pin;
         repeat (20) step();
      end
   endtask

   initial begin
      longint t0;
      int     toggles, lvl, plvl, cyc, spikes;

      rst = 1; en = 0; pin = 0; flt = 0; pne = 0; be = 0; clr = 0;
      step(); step();
      chk("rst_pin_out", {7'd0, o_pin_out}, 8'd0);
      chk("rst_evt",     {7'd0, o_evt},     8'd0);
      chk("rst_gc",      o_glitch_cnt,      8'd0);
      rst = 0; en = 1;
      repeat (5) step();

      // Minimum latency: visible after the third edge.
      pin = 1;
      step(); chk("n0_k",  {7'd0, o_pin_out}, 8'd0);
      step(); chk("n0_k1", {7'd0, o_pin_out}, 8'd0);
      step(); chk("n0_k2", {7'd0, o_pin_out}, 8'd1);
      chk("n0_pos", {7'd0, o_pos_evt}, 8'd1);
      chk("n0_evt", {7'd0, o_evt},     8'd1);
      step(); chk("n0_evt_end", {7'd0, o_evt}, 8'd0);
      chk("n0_gc", o_glitch_cnt, 8'd0);
      repeat (5) step();
      pin = 0;
      repeat (6) step();

      // N=3: five edges each way.
      flt = 3; pin = 1;
      repeat (5) step(); chk("n3_rise_early", {7'd0, o_pin_out}, 8'd0);
      step();            chk("n3_rise",       {7'd0, o_pin_out}, 8'd1);
      repeat (4) step();
      pin = 0;
      repeat (5) step(); chk("n3_fall_early", {7'd0, o_pin_out}, 8'd1);
      step();            chk("n3_fall",       {7'd0, o_pin_out}, 8'd0);
      chk("n3_neg", {7'd0, o_neg_evt}, 8'd1);
      chk("n3_evt", {7'd0, o_evt},     8'd0);
      repeat (5) step();

      // Glitch rejection and saturation.
      for (int g = 0; g < 300; g++) begin
         pin = 1; step(); step();
         pin = 0; step(); step(); step();
         if (g == 0) chk("glitch_one", o_glitch_cnt, 8'd1);
      end
      chk("glitch_sat", o_glitch_cnt, 8'd255);
      chk("glitch_lvl", {7'd0, o_pin_out}, 8'd0);
      pin = 1; step(); step();
      pin = 0; step(); step();
      clr = 1; step(); clr = 0;
      chk("glitch_clr", o_glitch_cnt, 8'd0);
      repeat (3) step();

      // Edge select.
      flt = 0; be = 1; pne = 0;
      toggle_phase();
      chk("be_evt", evt_cnt[7:0], 8'd4);
      be = 0; pne = 1;
      toggle_phase();
      chk("pne_evt", evt_cnt[7:0], 8'd2);
      en = 0; be = 1;
      toggle_phase();
      chk("en0_evt", evt_cnt[7:0], 8'd0);
      chk("en0_pos", pos_cnt[7:0], 8'd2);
      chk("en0_neg", neg_cnt[7:0], 8'd2);
      en = 1; be = 0; pne = 0;

      // Lowering the filter length mid-count.
      flt = 15; pin = 1;
      repeat (10) step(); chk("mid_hold",   {7'd0, o_pin_out}, 8'd0);
      flt = 4;
      step();             chk("mid_accept", {7'd0, o_pin_out}, 8'd1);
      repeat (3) step();

      // Reset during a falling filter run.
      flt = 15; pin = 0;
      repeat (8) step();
      rst = 1; evt_cnt = 0; neg_cnt = 0;
      step();
      chk("rst_mid_pin", {7'd0, o_pin_out}, 8'd0);
      rst = 0;
      repeat (20) step();
      chk("rst_mid_neg", neg_cnt[7:0], 8'd0);
      chk("rst_mid_evt", evt_cnt[7:0], 8'd0);

      // Pad toggling every 157 ns with one-cycle spikes, both edges selected.
      flt = 2; be = 1; en = 1;
      repeat (5) step();
      t0 = $time; plvl = 0; toggles = 0; evt_cnt = 0; cyc = 0; spikes = 0;
      while ($time - t0 < 157 * 40) begin
         lvl = int'((($time - t0) / 157) % 2);
         if (lvl != plvl) toggles++;
         plvl = lvl;
         pin = lvl[0];
         if (cyc % 16 == 8) begin pin = ~lvl[0]; spikes++; end
         step();
         cyc++;
      end
      pin = plvl[0];
      repeat (10) step();
      chk("timer_evts", evt_cnt[7:0], toggles[7:0]);

      // Randomised traffic against the model.
      for (int s = 0; s < 120; s++) begin
         pin = 1'($urandom);
         en  = ($urandom_range(0, 3) != 0);
         pne = 1'($urandom);
         be  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) flt = 4'($urandom);
         repeat ($urandom_range(1, 20)) begin
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
         end
      end
      clr = 0; rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
